// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface lsu_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per load/store, lane steering and load extension.
// Define LSU_MISALIGN_SPLIT_EN to run word-crossing accesses as two bus beats; otherwise they fault.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  lsu_if.master             mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS0 = 2'd1, BUS1 = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r;
  logic        done_r;
  logic        fault_r;
  logic [31:0] rdata_r;
  logic [31:0] hold_r;

  logic [1:0]        offset_s;
  logic [2:0]        size_s;
  logic [3:0]        base_s;
  logic [7:0]        lanes_s;
  logic              f3_bad_s;
  logic              illegal_s;
  logic              cross_s;
  logic              reject_s;
  logic              split_s;
  logic [63:0]       pair_s;
  logic [31:0]       load_s;
  logic [31:0]       lane_wdata_s;
  logic [ADDR_W-3:0] word_s;

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    rotl_bytes = d;
      2'd1:    rotl_bytes = {d[23:0], d[31:24]};
      2'd2:    rotl_bytes = {d[15:0], d[31:16]};
      2'd3:    rotl_bytes = {d[7:0], d[31:8]};
      default: rotl_bytes = d;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'h000000, d[7:0]};
      3'b101:  extend = {16'h0000, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign offset_s = addr[1:0];
  assign word_s   = addr[ADDR_W-1:2];
  assign stall    = req_valid & (is_load | is_store) & (state_r != RESP);
  assign done     = done_r;
  assign fault    = fault_r;
  assign rdata    = rdata_r;

  // Request decode: size, legality, word-crossing and the 8-lane window spanning both beats.
  always_comb begin
    case (funct3[1:0])
      2'b00:   begin size_s = 3'd1; base_s = 4'b0001; end
      2'b01:   begin size_s = 3'd2; base_s = 4'b0011; end
      default: begin size_s = 3'd4; base_s = 4'b1111; end
    endcase
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_bad_s = 1'b0;
      3'b100, 3'b101:         f3_bad_s = is_store;
      default:                f3_bad_s = 1'b1;
    endcase
    illegal_s    = f3_bad_s | (is_load & is_store);
    cross_s      = (({1'b0, offset_s} + size_s) > 3'd4);
    lanes_s      = {4'b0000, base_s} << offset_s;
    lane_wdata_s = rotl_bytes(wdata, offset_s);
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign reject_s = illegal_s;
  assign split_s  = cross_s;
`else
  assign reject_s = illegal_s | cross_s;
  assign split_s  = 1'b0;
`endif

  // Gather load bytes from the final beat (plus the held first beat of a split) and extend.
  always_comb begin
    if (state_r == BUS1) begin
      pair_s = {mem.mem_rdata, hold_r};
    end else begin
      pair_s = {32'h00000000, mem.mem_rdata};
    end
    load_s = extend(32'(pair_s >> {offset_s, 3'b000}), funct3);
  end

  // Bus outputs decoded from state and the held request; all zero outside a bus beat.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = {ADDR_W{1'b0}};
    mem.mem_wstrb = 4'b0000;
    mem.mem_wdata = 32'h00000000;
    case (state_r)
      BUS0: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = is_store;
        mem.mem_addr  = {word_s, 2'b00};
        mem.mem_wstrb = is_store ? lanes_s[3:0] : 4'b0000;
        mem.mem_wdata = is_store ? lane_wdata_s : 32'h00000000;
      end
      BUS1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = is_store;
        mem.mem_addr  = {word_s + (ADDR_W-2)'(1), 2'b00};
        mem.mem_wstrb = is_store ? lanes_s[7:4] : 4'b0000;
        mem.mem_wdata = is_store ? lane_wdata_s : 32'h00000000;
      end
      default: begin
        mem.mem_req = 1'b0;
      end
    endcase
  end

  // Transaction FSM with registered done/fault/rdata, cleared whenever not in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
      rdata_r <= 32'h00000000;
      hold_r  <= 32'h00000000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid & (is_load | is_store)) begin
            if (reject_s) begin
              state_r <= RESP;
              done_r  <= 1'b1;
              fault_r <= 1'b1;
              rdata_r <= 32'h00000000;
            end else begin
              state_r <= BUS0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUS0: begin
          if (mem.mem_ready) begin
            if (split_s) begin
              state_r <= BUS1;
              hold_r  <= mem.mem_rdata;
            end else begin
              state_r <= RESP;
              done_r  <= 1'b1;
              fault_r <= 1'b0;
              rdata_r <= is_load ? load_s : 32'h00000000;
            end
          end else begin
            state_r <= BUS0;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        BUS1: begin
          if (mem.mem_ready) begin
            state_r <= RESP;
            done_r  <= 1'b1;
            fault_r <= 1'b0;
            rdata_r <= is_load ? load_s : 32'h00000000;
          end else begin
            state_r <= BUS1;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          rdata_r <= 32'h00000000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu: a behavioural data memory answers each beat and
// expected completions are queued at issue and popped when done pulses.
module tb_lsu;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;

  lsu_if #(.ADDR_W(32)) bus ();

  lsu #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .is_load   (is_load),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .mem       (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          beats;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          tests = 0;
  int          fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    else return 32'h00000000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] d);
    logic [31:0] w;
    w = mem_rd(a);
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) w[8*i +: 8] = d[8*i +: 8];
    end
    mem_arr[a] = w;
  endtask

  task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int waits,
                       input logic [31:0] e_rdata, input logic e_fault, input int e_lat,
                       input int e_beats, input logic [31:0] e_addr0, input logic [3:0] e_s0,
                       input logic [3:0] e_s1, input logic [31:0] e_w0);
    exp_t e;
    exp_t got;
    int   cyc;
    int   beats;
    int   wcnt;
    logic seen;
    e = '{rdata: e_rdata, fault: e_fault, lat: e_lat, beats: e_beats};
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, " stall@accept"}, 32'(stall), 32'h1);
    cyc = 0; beats = 0; wcnt = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.mem_ready = 1'b0;
      if (done) begin
        seen = 1'b1;
        got = sb.pop_front();
        chk({tag, " rdata"}, rdata, got.rdata);
        chk({tag, " fault"}, 32'(fault), 32'(got.fault));
        chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
        chk({tag, " beats"}, 32'(beats), 32'(got.beats));
        chk({tag, " stall@resp"}, 32'(stall), 32'h0);
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      end else if (bus.mem_req) begin
        if (wcnt == 0) begin
          chk({tag, " mem_addr"}, bus.mem_addr, (beats == 0) ? e_addr0 : e_addr0 + 32'd4);
          chk({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'((beats == 0) ? e_s0 : e_s1));
          chk({tag, " mem_wdata"}, bus.mem_wdata, e_w0);
          chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(st));
        end
        if (wcnt == waits) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_rd(bus.mem_addr);
          if (bus.mem_we) mem_wr(bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
          beats++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    chk({tag, " done seen"}, 32'(seen), 32'h1);
    if (!seen) begin
      void'(sb.pop_front());
      req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, " done one-shot"}, 32'(done), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset done", 32'(done), 32'h0);
    chk("reset fault", 32'(fault), 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_req", 32'(bus.mem_req), 32'h0);
    chk("reset mem_we", 32'(bus.mem_we), 32'h0);
    chk("reset mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    do_op("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2, 1, 32'h100, 4'b1111, 4'b0000, 32'hDEADBEEF);
    do_op("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0, 3, 1, 32'h100, 4'b0000, 4'b0000, 32'h0);

    mem_arr[32'h200] = 32'h80FFFF12;
    do_op("lb", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 3, 32'hFFFFFF80, 1'b0, 5, 1, 32'h200, 4'b0000, 4'b0000, 32'h0);
    do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h00000080, 1'b0, 2, 1, 32'h200, 4'b0000, 4'b0000, 32'h0);
    do_op("lh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'hFFFF80FF, 1'b0, 2, 1, 32'h200, 4'b0000, 4'b0000, 32'h0);
    do_op("lhu", 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h000080FF, 1'b0, 2, 1, 32'h200, 4'b0000, 4'b0000, 32'h0);
    do_op("sh", 1'b0, 1'b1, 3'b001, 32'h001, 32'h0000ABCD, 0, 32'h0, 1'b0, 2, 1, 32'h000, 4'b0110, 4'b0000, 32'h00ABCD00);
    do_op("sb", 1'b0, 1'b1, 3'b000, 32'h207, 32'h000000EE, 2, 32'h0, 1'b0, 4, 1, 32'h204, 4'b1000, 4'b0000, 32'hEE000000);
    do_op("lw sb", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 0, 32'hEE000000, 1'b0, 2, 1, 32'h204, 4'b0000, 4'b0000, 32'h0);

    mem_arr[32'h100] = 32'h44332211;
    mem_arr[32'h104] = 32'h88776655;
    do_op("lh off1", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h00003322, 1'b0, 2, 1, 32'h100, 4'b0000, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    do_op("lw split", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h66554433, 1'b0, 3, 2, 32'h100, 4'b0000, 4'b0000, 32'h0);
    do_op("sw split", 1'b0, 1'b1, 3'b010, 32'h103, 32'hA1B2C3D4, 1, 32'h0, 1'b0, 5, 2, 32'h100, 4'b1000, 4'b0111, 32'hD4A1B2C3);
    do_op("lw split rb", 1'b1, 1'b0, 3'b010, 32'h103, 32'h0, 0, 32'hA1B2C3D4, 1'b0, 3, 2, 32'h100, 4'b0000, 4'b0000, 32'h0);
    do_op("lh split", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 32'hFFFFC3D4, 1'b0, 3, 2, 32'h100, 4'b0000, 4'b0000, 32'h0);
`else
    do_op("lw cross", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000, 4'b0000, 32'h0);
    do_op("sw cross", 1'b0, 1'b1, 3'b010, 32'h103, 32'hA1B2C3D4, 0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000, 4'b0000, 32'h0);
    do_op("lw unchanged", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h88776655, 1'b0, 2, 1, 32'h104, 4'b0000, 4'b0000, 32'h0);
    do_op("lh cross", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000, 4'b0000, 32'h0);
`endif

    do_op("ill f3 011", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000, 4'b0000, 32'h0);
    do_op("ill ld&st", 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000, 4'b0000, 32'h0);
    do_op("ill sbu", 1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0, 4'b0000, 4'b0000, 32'h0);

    // A ready pulse with no outstanding request must not complete anything.
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    chk("stray ready done", 32'(done), 32'h0);
    chk("stray ready mem_req", 32'(bus.mem_req), 32'h0);

    // Reset while a wait-stated load sits in BUS0.
    mem_arr[32'h300] = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk);
    #1;
    chk("rst-mid mem_req before", 32'(bus.mem_req), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst-mid mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst-mid done", 32'(done), 32'h0);
    rst = 1'b0; req_valid = 1'b0; is_load = 1'b0;
    @(posedge clk);
    #1;
    chk("rst-mid no done", 32'(done), 32'h0);
    chk("rst-mid idle", 32'(bus.mem_req), 32'h0);
    do_op("lw after rst", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h12345678, 1'b0, 2, 1, 32'h300, 4'b0000, 4'b0000, 32'h0);

    chk("scoreboard empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
